// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: folds WIDTH MSB-first slice flags (eq/lt/gt) into one
// whole-word relation with a one-word result holding stage and valid/ready handshakes.
module serial_mag_comparator #(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_eq,
    input  logic in_lt,
    input  logic in_gt,
    output logic out_valid,
    input  logic out_ready,
    output logic out_eq,
    output logic out_lt,
    output logic out_gt,
    output logic out_err,
    output logic busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          locked;
    logic          lt_q;
    logic          gt_q;
    logic          err_q;
    logic          all_eq;

    logic accept;
    logic onehot;
    logic last;
    logic lock_now;
    logic err_n;
    logic all_eq_n;
    logic lt_n;
    logic gt_n;
    logic locked_n;

    assign accept = in_valid && in_ready;
    assign onehot = ({in_eq, in_lt, in_gt} == 3'b100) || ({in_eq, in_lt, in_gt} == 3'b010) ||
                    ({in_eq, in_lt, in_gt} == 3'b001);
    assign last   = (cnt == CW'(WIDTH - 1));

    // Only a well-formed lt/gt slice may lock; malformed slices just poison the word.
    always_comb begin
        lock_now = onehot && !in_eq && !locked;
        err_n    = err_q || !onehot;
        all_eq_n = all_eq && onehot && in_eq;
        lt_n     = lock_now ? in_lt : lt_q;
        gt_n     = lock_now ? in_gt : gt_q;
        locked_n = locked || lock_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            locked    <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            err_q     <= 1'b0;
            all_eq    <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_eq    <= 1'b0;
            out_lt    <= 1'b0;
            out_gt    <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                StIdle, StAccum: begin
                    if (accept) begin
                        cnt    <= cnt + 1'b1;
                        locked <= locked_n;
                        lt_q   <= lt_n;
                        gt_q   <= gt_n;
                        err_q  <= err_n;
                        all_eq <= all_eq_n;
                        if (last) begin
                            state     <= StHold;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            out_err   <= err_n;
                            out_eq    <= !err_n && all_eq_n;
                            out_lt    <= !err_n && lt_n;
                            out_gt    <= !err_n && gt_n;
                        end else begin
                            state    <= StAccum;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end else begin
                        // Gap cycle: hold position; in_ready rises here right after reset.
                        in_ready <= 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        cnt       <= '0;
                        locked    <= 1'b0;
                        lt_q      <= 1'b0;
                        gt_q      <= 1'b0;
                        err_q     <= 1'b0;
                        all_eq    <= 1'b1;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_eq    <= 1'b0;
                        out_lt    <= 1'b0;
                        out_gt    <= 1'b0;
                        out_err   <= 1'b0;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state    <= StIdle;
                    cnt      <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
